cmd_frame_decoder: RTL and testbench



---
 rtl/cmd_frame_decoder_pkg.sv | 32 +++
 rtl/cmd_frame_decoder_gap.sv | 31 +++
 rtl/cmd_frame_decoder.sv | 192 +++++++++++++++++++
 tb/tb_cmd_frame_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_decoder_pkg.sv
// Shared constants, state encoding and helpers for the command frame decoder.
package cmd_frame_decoder_pkg;

  // Frame header byte and the two response codes returned to the host.
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Payload is one 32-bit little-endian word.
  localparam int FRAME_DATA_BYTES = 4;
  localparam int BYTE_CNT_W       = $clog2(FRAME_DATA_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CSUM,
    RESP0,
    RESP1
  } state_t;

  // States in which a frame is being received and the gap timer runs.
  function automatic logic in_frame(input state_t s);
    return (s == ADDR) || (s == DATA) || (s == CSUM);
  endfunction

  // States in which a response byte is offered to the transmitter.
  function automatic logic in_resp(input state_t s);
    return (s == RESP0) || (s == RESP1);
  endfunction

endpackage

// File: rtl/cmd_frame_decoder_gap.sv
// Saturating inter-byte gap timer: counts enabled cycles since the last
// clear and pulses expired once when the count reaches TIMEOUT_CYCLES.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT   = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // Count idle enabled cycles; restart on clear or whenever disabled, hold at SAT.
  always_ff @(posedge clk) begin
    if (reset || !enable || clear) begin
      count <= '0;
    end else if (count != SAT) begin
      count <= count + CNT_W'(1);
    end
  end

  // The expiry does not look at clear, so a byte landing on the expiry cycle loses.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/cmd_frame_decoder.sv
// Parses A5/ADDR/D0..D3/CSUM write frames from the UART byte stream, issues
// one register write per valid frame and answers every frame with ACK/NAK
// followed by the echoed address byte.
module cmd_frame_decoder
  import cmd_frame_decoder_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              frame_err,
  output logic              busy
);

  state_t                state;
  state_t                state_next;

  logic [7:0]            addr_reg;
  logic [31:0]           data_acc;
  logic [7:0]            csum_acc;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  resp_ack;

  logic                  timer_enable;
  logic                  timer_expired;
  logic                  byte_take;
  logic                  last_data_byte;
  logic                  csum_ok;
  logic                  addr_ok;
  logic                  frame_good;

  assign timer_enable = in_frame(state);

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (timer_enable),
    .clear   (rx_valid),
    .expired (timer_expired)
  );

  // A frame byte counts only if the gap timer has not fired in the same cycle.
  assign byte_take      = in_frame(state) && rx_valid && !timer_expired;
  assign last_data_byte = (byte_cnt == BYTE_CNT_W'(FRAME_DATA_BYTES - 1));
  assign csum_ok        = (rx_data == csum_acc);
  assign addr_ok        = ({24'd0, addr_reg} < 32'(NUM_REGS));
  assign frame_good     = csum_ok && addr_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: frame reception, timeout abort and the two-byte response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == HDR)) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (timer_expired) begin
          state_next = IDLE;
        end else if (rx_valid) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (timer_expired) begin
          state_next = IDLE;
        end else if (rx_valid && last_data_byte) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        if (timer_expired) begin
          state_next = IDLE;
        end else if (rx_valid) begin
          state_next = RESP0;
        end
      end
      RESP0: begin
        if (tx_ready) begin
          state_next = RESP1;
        end
      end
      RESP1: begin
        if (tx_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs: response byte is a function of state, so it holds until accepted.
  always_comb begin
    busy     = (state != IDLE);
    tx_valid = in_resp(state);
    tx_data  = 8'h00;
    case (state)
      RESP0:   tx_data = resp_ack ? ACK : NAK;
      RESP1:   tx_data = addr_reg;
      default: tx_data = 8'h00;
    endcase
  end

  // Frame datapath: address latch, word assembly, checksum, write strobe and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= '0;
      data_acc  <= '0;
      csum_acc  <= '0;
      byte_cnt  <= '0;
      resp_ack  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;

      if (timer_expired) begin
        frame_err <= 1'b1;
      end

      if (in_resp(state) && rx_valid) begin
        frame_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == HDR)) begin
            data_acc <= '0;
            csum_acc <= '0;
            byte_cnt <= '0;
          end
        end
        ADDR: begin
          if (byte_take) begin
            addr_reg <= rx_data;
            csum_acc <= rx_data;
            byte_cnt <= '0;
          end
        end
        DATA: begin
          if (byte_take) begin
            data_acc[8*byte_cnt +: 8] <= rx_data;
            csum_acc                  <= csum_acc ^ rx_data;
            byte_cnt                  <= byte_cnt + BYTE_CNT_W'(1);
          end
        end
        CSUM: begin
          if (byte_take) begin
            resp_ack <= frame_good;
            if (frame_good) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_reg[ADDR_W-1:0];
              wr_data <= data_acc;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Self-checking bench for cmd_frame_decoder: directed frames from the test
// plan plus randomized frames, compared with a frame-level reference model.
module tb_cmd_frame_decoder;
  import cmd_frame_decoder_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int TIMEOUT  = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              frame_err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Observations collected by the monitor for the frame under test.
  logic [7:0]  tx_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          err_cnt = 0;

  // Reference copy of the last committed register write (reset value 0).
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_data = 32'h0;

  // 0: tx_ready high, 1: random, 2: held low.
  int ready_mode = 0;

  always #5 clk = ~clk;

  cmd_frame_decoder #(
    .NUM_REGS       (NUM_REGS),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Transmitter readiness driver.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(1, 0));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: record writes, error pulses and accepted response bytes.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        wa_q.push_back(32'(wr_addr));
        wd_q.push_back(wr_data);
        checkOutput("ack_with_wr", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, ACK});
      end
      if (frame_err) err_cnt++;
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end
  end

  function automatic logic [7:0] xorSum(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction

  function automatic logic [55:0] mkFrame(input logic [7:0] a, input logic [31:0] d,
                                          input logic [7:0] cs);
    return {cs, d, a, HDR};
  endfunction

  task automatic clearObs();
    tx_q.delete();
    wa_q.delete();
    wd_q.delete();
    err_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic sendFrame(input logic [55:0] f, input int gapMax);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(f[8*i +: 8], (i == 6) ? 0 : int'($urandom_range(gapMax, 0)));
    end
  endtask

  task automatic waitIdle();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Frame-level model: good checksum and in-range address give a write and ACK.
  task automatic expectFrame(input logic [55:0] f, input int extraErr);
    logic [7:0]  a;
    logic [31:0] d;
    bit          ok;
    a  = f[15:8];
    d  = f[47:16];
    ok = (xorSum(a, d) == f[55:48]) && (int'(a) < NUM_REGS);
    checkOutput("wr_count", 32'(wa_q.size()), ok ? 32'd1 : 32'd0);
    if (ok && wa_q.size() > 0) begin
      checkOutput("wr_addr", wa_q[0], 32'(a));
      checkOutput("wr_data", wd_q[0], d);
      last_addr = a;
      last_data = d;
    end
    checkOutput("tx_count", 32'(tx_q.size()), 32'd2);
    if (tx_q.size() > 0) checkOutput("tx_code", 32'(tx_q[0]), ok ? 32'(ACK) : 32'(NAK));
    if (tx_q.size() > 1) checkOutput("tx_addr", 32'(tx_q[1]), 32'(a));
    checkOutput("err_count", 32'(err_cnt), 32'((ok ? 0 : 1) + extraErr));
    checkOutput("wr_hold_addr", 32'(wr_addr), 32'(last_addr));
    checkOutput("wr_hold_data", wr_data, last_data);
  endtask

  task automatic runFrame(input logic [55:0] f, input int gapMax);
    clearObs();
    sendFrame(f, gapMax);
    waitIdle();
    expectFrame(f, 0);
  endtask

  initial begin
    logic [55:0] f;
    logic [7:0]  a;
    logic [31:0] d;
    logic [7:0]  cs;
    logic [7:0]  g;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Valid write with tx_ready high; checksum follows the XOR rule.
    ready_mode = 0;
    runFrame(mkFrame(8'h03, 32'h12345678, xorSum(8'h03, 32'h12345678)), 0);
    // Bad checksum, then out-of-range address.
    runFrame(mkFrame(8'h03, 32'h12345678, 8'h00), 0);
    runFrame(mkFrame(8'h10, 32'h00000001, 8'h11), 0);
    // Header value inside the frame is plain data.
    runFrame(mkFrame(8'h01, 32'hA5A5A5A5, xorSum(8'h01, 32'hA5A5A5A5)), 1);

    // Gap timeout aborts silently apart from one error pulse.
    clearObs();
    applyStimulus(HDR, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h01, 0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    checkOutput("to_err_count", 32'(err_cnt), 32'd1);
    checkOutput("to_tx_count", 32'(tx_q.size()), 32'd0);
    checkOutput("to_wr_count", 32'(wa_q.size()), 32'd0);
    checkOutput("to_busy", 32'(busy), 32'd0);
    runFrame(mkFrame(8'h02, 32'h00000001, 8'h03), 0);

    // Backpressure with a stray byte during the stall.
    clearObs();
    ready_mode = 2;
    f = mkFrame(8'h07, 32'hCAFE0123, xorSum(8'h07, 32'hCAFE0123));
    sendFrame(f, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(tx_valid), 32'd1);
      checkOutput("stall_data", 32'(tx_data), 32'(ACK));
      if (i == 8) begin
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
    end
    ready_mode = 0;
    waitIdle();
    expectFrame(f, 1);

    // Reset in DATA after D1.
    clearObs();
    applyStimulus(HDR, 0);
    applyStimulus(8'h05, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rstmid_wr_en", 32'(wr_en), 32'd0);
    reset     = 1'b0;
    last_addr = 8'h00;
    last_data = 32'h0;
    repeat (5) @(negedge clk);
    checkOutput("rstmid_wr_count", 32'(wa_q.size()), 32'd0);
    checkOutput("rstmid_tx_count", 32'(tx_q.size()), 32'd0);
    checkOutput("rstmid_err_count", 32'(err_cnt), 32'd0);
    runFrame(mkFrame(8'h09, 32'h0BADF00D, xorSum(8'h09, 32'h0BADF00D)), 0);

    // Randomized frames, random readiness, stray non-header bytes in IDLE.
    for (int n = 0; n < 24; n++) begin
      ready_mode = int'($urandom_range(1, 0));
      a  = 8'($urandom_range(19, 0));
      d  = $urandom;
      cs = xorSum(a, d);
      if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
      f = mkFrame(a, d, cs);
      clearObs();
      if ($urandom_range(1, 0) == 1) begin
        g = 8'($urandom);
        if (g == HDR) g = 8'h00;
        applyStimulus(g, 1);
      end
      sendFrame(f, 3);
      waitIdle();
      expectFrame(f, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
